// File: rtl/sram_controller_pkg.sv
// Shared constants and FSM state encoding for the 32-bit to 16-bit SRAM bridge.
package sram_controller_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned SRAM_DQ_W     = 16;
  localparam int unsigned SRAM_ADDR_W   = 18;
  localparam int unsigned ACCESS_CYCLES = 6;
  localparam logic [DATA_W-1:0] SRAM_BASE = 32'd1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC1  = 3'd1,
    ACC2  = 3'd2,
    WAIT1 = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sram_controller.sv
// Fixed-latency bridge from the memory stage (32-bit word accesses) to a
// 16-bit asynchronous SRAM: low half-word in ACC1, high half-word in ACC2.
module sram_controller
  import sram_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      writeData,
  output logic [DATA_W-1:0]      readData,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  state_t              state;
  logic                op_wr;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   addr_off;
  logic                req;
  logic                in_acc;
  logic                wr_acc;
  logic                rd_acc;
  logic [SRAM_DQ_W-1:0] dq_out;
  logic                unused_addr_bits;

  assign req      = wr_en | rd_en;
  assign addr_off = addr_q - SRAM_BASE;
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  // Request latch and access sequencing; write wins when both enables are set
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state   <= ACC1;
            op_wr   <= wr_en;
            addr_q  <= address;
            wdata_q <= writeData;
          end
        end
        ACC1: begin
          state <= ACC2;
          if (!op_wr) readData[15:0] <= SRAM_DQ;
        end
        ACC2: begin
          state <= WAIT1;
          if (!op_wr) readData[31:16] <= SRAM_DQ;
        end
        WAIT1:   state <= WAIT2;
        WAIT2:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes decode from state; reset gates them so an aborted write
  // never commits its remaining half-word.
  always_comb begin
    in_acc = (state == ACC1) || (state == ACC2);
    wr_acc = in_acc && op_wr && !rst;
    rd_acc = in_acc && !op_wr && !rst;
    dq_out = (state == ACC2) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_ADDR = {addr_off[18:2], (state == ACC2)};
  assign SRAM_WE_N = ~wr_acc;
  assign SRAM_OE_N = ~rd_acc;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = wr_acc ? dq_out : 16'hzzzz;

  assign ready = (state == DONE) || ((state == IDLE) && !req);

endmodule
